// File: rtl/data_mem_pkg.sv
// Shared types for the parametrised data memory.
// Sweep FSM states and read-latency selectors.
package data_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

  localparam int DMEM_LAT_COMB = 0;
  localparam int DMEM_LAT_REG  = 1;

endpackage

// File: rtl/data_mem_param_if.sv
// Load/store bus between the core datapath and the data memory.
// master = datapath side, slave = memory side.
interface data_mem_param_if #(
  parameter int DW = 8,
  parameter int AW = 8
);

  logic [AW-1:0] DataAddress;
  logic          ReadMem;
  logic          WriteMem;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;
  logic          DataValid;
  logic          Busy;
  logic          AccessErr;

  modport master (
    output DataAddress,
    output ReadMem,
    output WriteMem,
    output DataIn,
    input  DataOut,
    input  DataValid,
    input  Busy,
    input  AccessErr
  );

  modport slave (
    input  DataAddress,
    input  ReadMem,
    input  WriteMem,
    input  DataIn,
    output DataOut,
    output DataValid,
    output Busy,
    output AccessErr
  );

endinterface

// File: rtl/data_mem_clear_fsm.sv
// Post-reset clear sweep: walks every word once, then parks in READY.
// Busy also covers the time reset itself is held low.
module data_mem_clear_fsm
  import data_mem_pkg::*;
#(
  parameter int AW             = 8,
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          CLK,
  input  logic          reset,
  output logic          Busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  // One extra bit so DEPTH == 2**AW still reaches its last word cleanly
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam dmem_state_t RST_ST =
    CLEAR_ON_RESET ? CLEAR : READY;

  dmem_state_t   state;
  dmem_state_t   state_d;
  logic [PW-1:0] clr_ptr;
  logic [PW-1:0] clr_ptr_d;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= RST_ST;
      clr_ptr <= '0;
    end else begin
      state   <= state_d;
      clr_ptr <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state;
    clr_ptr_d = clr_ptr;
    clr_we    = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr + 1'b1;
        if (clr_ptr == LAST) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
    endcase
  end

  assign Busy     = !reset || (state == CLEAR);
  assign clr_addr = clr_ptr[AW-1:0];

endmodule

// File: rtl/data_mem_param.sv
// Parametrised data memory with one shared address, post-reset clear
// sweep, selectable read latency and request error reporting.
module data_mem_param
  import data_mem_pkg::*;
#(
  parameter int            DW             = 8,
  parameter int            AW             = 8,
  parameter int            DEPTH          = 256,
  parameter int            READ_LATENCY   = 1,
  parameter bit            CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0] INIT_VALUE     = '0
) (
  input  logic             CLK,
  input  logic             reset,
  data_mem_param_if.slave  bus
);

  localparam int PW = AW + 1;

  logic [DW-1:0] core [DEPTH];

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          addr_ok;
  logic          req;
  logic          acc;
  logic          rd_acc;
  logic          wr_acc;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rdata;
  logic          err_q;

  data_mem_clear_fsm #(
    .AW             (AW),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .CLK      (CLK),
    .reset    (reset),
    .Busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Unsigned compare: out-of-range addresses never alias
  assign addr_ok = {1'b0, bus.DataAddress} < PW'(DEPTH);
  assign req     = bus.ReadMem | bus.WriteMem;
  assign acc     = !busy && addr_ok;
  assign rd_acc  = bus.ReadMem & acc;
  assign wr_acc  = bus.WriteMem & acc;

  // Sweep owns the single write port while it runs
  assign mem_we    = clr_we | wr_acc;
  assign mem_waddr = clr_we ? clr_addr : bus.DataAddress;
  assign mem_wdata = clr_we ? INIT_VALUE : bus.DataIn;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      core[mem_waddr] <= mem_wdata;
    end
  end

  assign rdata = core[bus.DataAddress];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= req & ~acc;
    end
  end

  assign bus.AccessErr = err_q;
  assign bus.Busy      = busy;

  if (READ_LATENCY == DMEM_LAT_COMB) begin : g_comb
    // Array write lands at the edge, so a same-cycle read sees the old word
    assign bus.DataOut   = rd_acc ? rdata : '0;
    assign bus.DataValid = rd_acc;
  end else begin : g_reg
    logic [DW-1:0] dout_q;
    logic          dv_q;

    always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= wr_acc ? bus.DataIn : rdata;
        end
      end
    end

    assign bus.DataOut   = dout_q;
    assign bus.DataValid = dv_q;
  end

endmodule
